// File: rtl/render_pkg.sv
// render_pkg: shared state encoding and screen/coordinate defaults
// reused by the render_* drawing blocks.
package render_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } rect_state_e;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int COLOR_W_DEF  = 3;
  localparam int DIM_W_DEF    = 5;

endpackage

// File: rtl/rect_scan_counter.sv
// rect_scan_counter: row-major dx/dy walker over a w x h box.
// Exposes the next (dx,dy) so the owner can register the next pixel.
module rect_scan_counter #(
  parameter int DIM_W = 5
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIM_W-1:0] w_i,
  input  logic [DIM_W-1:0] h_i,
  output logic [DIM_W-1:0] nx_o,
  output logic [DIM_W-1:0] ny_o,
  output logic             last_o
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic [DIM_W-1:0] dx_q;
  logic [DIM_W-1:0] dy_q;
  logic             row_end;

  // next position: wrap dx at end of row, then step dy
  always_comb begin
    row_end = (dx_q == w_i - ONE);
    last_o  = row_end && (dy_q == h_i - ONE);
    if (row_end) begin
      nx_o = '0;
      ny_o = dy_q + ONE;
    end else begin
      nx_o = dx_q + ONE;
      ny_o = dy_q;
    end
  end

  // position register: cleared while not scanning, steps on en
  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      dx_q <= '0;
      dy_q <= '0;
    end else if (en_i) begin
      dx_q <= nx_o;
      dy_q <= ny_o;
    end
  end

endmodule

// File: rtl/render_rect_engine.sv
// render_rect_engine: rectangle fill/outline plotter for the VGA adapter.
// Optional outline mode is enabled by defining RENDER_RECT_OUTLINE_EN.
module render_rect_engine
  import render_pkg::*;
#(
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int DIM_W    = DIM_W_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [DIM_W-1:0]   w_in,
  input  logic [DIM_W-1:0]   h_in,
  input  logic [COLOR_W-1:0] color_in,
`ifdef RENDER_RECT_OUTLINE_EN
  input  logic               outline,
`endif
  input  logic               pause,
  output logic               ready,
  output logic               done,
  output logic [X_W-1:0]     r_x,
  output logic [Y_W-1:0]     r_y,
  output logic [COLOR_W-1:0] r_color,
  output logic               writeEn
);

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  rect_state_e        state_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [DIM_W-1:0]   w_q;
  logic [DIM_W-1:0]   h_q;
  logic [X_W-1:0]     r_x_q;
  logic [Y_W-1:0]     r_y_q;
  logic [COLOR_W-1:0] r_c_q;
  logic               we_q;

  logic               idle;
  logic [DIM_W-1:0]   nx;
  logic [DIM_W-1:0]   ny;
  logic               last;
  logic [X_W-1:0]     bx;
  logic [Y_W-1:0]     by;
  logic [DIM_W-1:0]   ox;
  logic [DIM_W-1:0]   oy;
  logic [X_W:0]       sx_d;
  logic [Y_W:0]       sy_d;
  logic               vis_d;
  logic               wr_d;

  assign idle = (state_q == ST_IDLE);

  rect_scan_counter #(
    .DIM_W (DIM_W)
  ) u_scan (
    .clk    (clk),
    .rst_i  (resetn),
    .clr_i  (state_q != ST_DRAW),
    .en_i   ((state_q == ST_DRAW) && !pause && !last),
    .w_i    (w_q),
    .h_i    (h_q),
    .nx_o   (nx),
    .ny_o   (ny),
    .last_o (last)
  );

  // next pixel: pixel 0 comes straight from the command inputs
  always_comb begin
    bx    = idle ? x_in : x_q;
    by    = idle ? y_in : y_q;
    ox    = idle ? '0 : nx;
    oy    = idle ? '0 : ny;
    sx_d  = {1'b0, bx} + (X_W+1)'(ox);
    sy_d  = {1'b0, by} + (Y_W+1)'(oy);
    vis_d = (sx_d < SCR_W) && (sy_d < SCR_H);
  end

`ifdef RENDER_RECT_OUTLINE_EN
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic             ol_q;
  logic             ol_c;
  logic [DIM_W-1:0] wc;
  logic [DIM_W-1:0] hc;
  logic             bd_d;

  // outline flag travels with the command
  always_ff @(posedge clk) begin
    if (resetn) begin
      ol_q <= 1'b0;
    end else if (idle && start) begin
      ol_q <= outline;
    end
  end

  // in outline mode only border pixels are plotted
  always_comb begin
    ol_c = idle ? outline : ol_q;
    wc   = idle ? w_in : w_q;
    hc   = idle ? h_in : h_q;
    bd_d = (ox == '0) || (ox == wc - ONE)
        || (oy == '0) || (oy == hc - ONE);
    wr_d = vis_d && (!ol_c || bd_d);
  end
`else
  assign wr_d = vis_d;
`endif

  // control FSM with registered pixel outputs
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      r_x_q   <= '0;
      r_y_q   <= '0;
      r_c_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            x_q <= x_in;
            y_q <= y_in;
            w_q <= w_in;
            h_q <= h_in;
            if ((w_in == '0) || (h_in == '0)) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_DRAW;
              r_x_q   <= sx_d[X_W-1:0];
              r_y_q   <= sy_d[Y_W-1:0];
              r_c_q   <= color_in;
              we_q    <= wr_d;
            end
          end
        end
        ST_DRAW: begin
          if (!pause) begin
            if (last) begin
              state_q <= ST_DONE;
              we_q    <= 1'b0;
            end else begin
              r_x_q <= sx_d[X_W-1:0];
              r_y_q <= sy_d[Y_W-1:0];
              we_q  <= wr_d;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // a stalled sink must never see a strobe for the held pixel
  assign writeEn = we_q && !pause;
  assign ready   = (state_q == ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign r_x     = r_x_q;
  assign r_y     = r_y_q;
  assign r_color = r_c_q;

endmodule

// File: tb/tb_render_rect_engine.sv
// tb_render_rect_engine: directed checks for render_rect_engine.
// Covers reset, fill, clipping, zero size, busy start, pause, outline.
module tb_render_rect_engine;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [4:0] w_in;
  logic [4:0] h_in;
  logic [2:0] color_in;
  logic       pause;
  logic       ready;
  logic       done;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_color;
  logic       writeEn;
`ifdef RENDER_RECT_OUTLINE_EN
  logic       outline;
`endif

  int vectors;
  int miscompares;

  render_rect_engine dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .x_in     (x_in),
    .y_in     (y_in),
    .w_in     (w_in),
    .h_in     (h_in),
    .color_in (color_in),
`ifdef RENDER_RECT_OUTLINE_EN
    .outline  (outline),
`endif
    .pause    (pause),
    .ready    (ready),
    .done     (done),
    .r_x      (r_x),
    .r_y      (r_y),
    .r_color  (r_color),
    .writeEn  (writeEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // start a rectangle, then check every cycle against the row-major scan
  task automatic run_rect(input int x, input int y,
                          input int w, input int h,
                          input int c, input bit poke,
                          output int nw);
    int ex;
    int ey;
    int k;
    x_in     = x[7:0];
    y_in     = y[6:0];
    w_in     = w[4:0];
    h_in     = h[4:0];
    color_in = c[2:0];
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    x_in     = 8'd0;
    y_in     = 7'd0;
    color_in = 3'd0;
    nw       = 0;
    for (int cy = 1; cy <= w * h + 2; cy++) begin
      @(negedge clk);
      k = cy - 1;
      if (k < w * h) begin
        ex = x + k % w;
        ey = y + k / w;
        chk("we", writeEn, (ex < 160) && (ey < 120));
        chk("rx", r_x, ex & 255);
        chk("ry", r_y, ey & 127);
        chk("col", r_color, c);
      end else begin
        chk("we_idle", writeEn, 0);
      end
      chk("done", done, cy == w * h + 1);
      if (cy == w * h + 2) chk("ready", ready, 1);
      nw += int'(writeEn);
      if (poke && cy == 2) begin
        start    = 1'b1;
        x_in     = 8'd50;
        y_in     = 7'd50;
        w_in     = 5'd2;
        h_in     = 5'd2;
        color_in = 3'd2;
      end
      if (poke && cy == 4) start = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  int p_we [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
  int p_rx [10] = '{30, 31, 32, 32, 32, 30, 31, 32, 32, 32};
  int p_ry [10] = '{40, 40, 40, 40, 40, 41, 41, 41, 41, 41};

  initial begin
    int nw;
    bit seen_done;
    bit seen_we;
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b1;
    start       = 1'b0;
    pause       = 1'b0;
    x_in        = '0;
    y_in        = '0;
    w_in        = '0;
    h_in        = '0;
    color_in    = '0;
`ifdef RENDER_RECT_OUTLINE_EN
    outline     = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_we", writeEn, 0);
    chk("rst_rx", r_x, 0);
    chk("rst_ry", r_y, 0);
    chk("rst_col", r_color, 0);
    resetn = 1'b0;
    @(posedge clk);
    #1;

    // 4x4 fill at (10,20), start poked while busy
    run_rect(10, 20, 4, 4, 5, 1'b1, nw);
    chk("basic_writes", nw, 16);

    // 4x4 straddling the bottom-right corner
    run_rect(158, 118, 4, 4, 3, 1'b0, nw);
    chk("clip_writes", nw, 4);

    // degenerate width
    run_rect(7, 7, 0, 3, 1, 1'b0, nw);
    chk("zero_writes", nw, 0);

    // zero size again, with start held during DONE
    x_in  = 8'd1;
    y_in  = 7'd1;
    w_in  = 5'd0;
    h_in  = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    @(negedge clk);
    chk("z_done", done, 1);
    chk("z_we", writeEn, 0);
    start    = 1'b1;
    w_in     = 5'd8;
    h_in     = 5'd8;
    color_in = 3'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("z_busy_ready", ready, 1);
    chk("z_busy_we", writeEn, 0);
    chk("z_busy_done", done, 0);
    @(posedge clk);
    #1;

    // 3x2 at (30,40) with a two-cycle stall on pixel 2
    x_in     = 8'd30;
    y_in     = 7'd40;
    w_in     = 5'd3;
    h_in     = 5'd2;
    color_in = 3'd6;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      pause = (c == 3 || c == 4);
      @(negedge clk);
      chk("p_we", writeEn, p_we[c-1]);
      chk("p_rx", r_x, p_rx[c-1]);
      chk("p_ry", r_y, p_ry[c-1]);
      chk("p_done", done, c == 9);
      @(posedge clk);
      #1;
    end
    pause = 1'b0;
    chk("p_ready", ready, 1);

    // reset in the middle of a draw
    x_in     = 8'd5;
    y_in     = 7'd6;
    w_in     = 5'd4;
    h_in     = 5'd4;
    color_in = 3'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("mr_ready", ready, 1);
    chk("mr_done", done, 0);
    chk("mr_we", writeEn, 0);
    chk("mr_rx", r_x, 0);
    chk("mr_ry", r_y, 0);
    chk("mr_col", r_color, 0);
    seen_done = 1'b0;
    seen_we   = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_done |= done;
      seen_we   |= writeEn;
    end
    chk("mr_no_done", seen_done, 0);
    chk("mr_no_we", seen_we, 0);
    @(posedge clk);
    #1;

`ifdef RENDER_RECT_OUTLINE_EN
    // 4x4 outline: interior skipped, timing unchanged
    x_in     = 8'd10;
    y_in     = 7'd20;
    w_in     = 5'd4;
    h_in     = 5'd4;
    color_in = 3'd5;
    outline  = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    outline = 1'b0;
    nw      = 0;
    for (int cy = 1; cy <= 17; cy++) begin
      @(negedge clk);
      if (cy <= 16) begin
        chk("ol_we", writeEn,
            ((cy-1) % 4 == 0) || ((cy-1) % 4 == 3) ||
            ((cy-1) / 4 == 0) || ((cy-1) / 4 == 3));
      end
      chk("ol_done", done, cy == 17);
      nw += int'(writeEn);
    end
    chk("ol_writes", nw, 12);
    @(posedge clk);
    #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
